soc_run_controller: RTL and testbench

Parametrised run-control block for FPGA builds of hack_soc. It replaces ad-hoc gated slow clocks with a single-cycle clock-enable (`soc_clk_en`) on the board clock. The enable is generated by a programmable divider, with debounced run/pause and single-step/burst-step buttons. The block also sequences ROM loading and the release of `hack_external_reset`.

---
 rtl/soc_run_pkg.sv | 23 ++
 rtl/button_debounce.sv | 59 +++++
 rtl/soc_run_controller.sv | 156 +++++++++++++++
 tb/tb_soc_run_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_run_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_run_pkg
// Purpose  : Shared types for the hack_soc run controller. Provides the
//            run-state encoding seen on the run_state output.
// Contents : RUN_STATE_W - width of the run_state encoding
//            run_state_t - LOAD/RELEASE/RUN/PAUSE/STEP state enumeration
// Revision : 1.0 - initial release
// ============================================================================
package soc_run_pkg;

    localparam int RUN_STATE_W = 3;

    typedef enum logic [RUN_STATE_W-1:0] {
        ST_LOAD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_STEP    = 3'd4
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Two-flop synchronizer plus stability counter for one raw button.
//            The debounced level follows the synchronized input only after
//            CYCLES consecutive samples that differ from the current level.
// Ports    : clk     - board clock
//            reset_n - synchronous active-low reset
//            button  - raw, asynchronous, active-high button
//            level   - debounced button level
//            press   - one-cycle pulse on each debounced 0->1 transition
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int CYCLES = 40
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    output logic level,
    output logic press
);

    localparam int              CNT_W  = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_cnt   <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            r_sync0 <= button;
            r_sync1 <= r_sync0;
            press   <= 1'b0;
            // r_cnt holds how many consecutive samples have disagreed with
            // the current level; any agreeing sample restarts the count.
            if (r_sync1 != level) begin
                if (r_cnt == c_last) begin
                    level <= r_sync1;
                    press <= r_sync1;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/soc_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : soc_run_controller
// Purpose  : Run control for FPGA builds of hack_soc. Produces a single-cycle
//            clock enable from a programmable divider, sequences ROM loading
//            and CPU reset release, and offers run/pause and burst stepping
//            from two debounced buttons.
// Ports    : clk, reset_n          - board clock, synchronous active-low reset
//            btn_run_pause, btn_step - raw active-high buttons
//            div_sel               - tick period = 2^div_sel clk cycles
//            step_count            - ticks per step press (0 treated as 1)
//            load_done             - ROM loader finished (level)
//            load_run              - run request to the ROM loader
//            hack_external_reset   - reset hold for the CPU core
//            soc_clk_en            - one-clk enable pulse for soc and loader
//            run_state             - current state encoding
//            cycle_count           - ticks issued since reset release
// Revision : 1.0 - initial release
// ============================================================================
module soc_run_controller
    import soc_run_pkg::*;
#(
    parameter int DIV_WIDTH         = 15,
    parameter int DEBOUNCE_CYCLES   = 40,
    parameter int BURST_WIDTH       = 8,
    parameter int START_PAUSED      = 0,
    parameter int CYCLE_COUNT_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             btn_run_pause,
    input  logic                             btn_step,
    input  logic [$clog2(DIV_WIDTH+1)-1:0]   div_sel,
    input  logic [BURST_WIDTH-1:0]           step_count,
    input  logic                             load_done,
    output logic                             load_run,
    output logic                             hack_external_reset,
    output logic                             soc_clk_en,
    output logic [RUN_STATE_W-1:0]           run_state,
    output logic [CYCLE_COUNT_WIDTH-1:0]     cycle_count
);

    localparam int SEL_W = $clog2(DIV_WIDTH + 1);

    logic [DIV_WIDTH-1:0]   r_div_cnt;
    logic [DIV_WIDTH-1:0]   w_mask;
    logic [SEL_W-1:0]       w_sel;
    logic                   w_tick;
    run_state_t             r_state;
    logic [BURST_WIDTH-1:0] r_burst;
    logic                   w_rp_press;
    logic                   w_st_press;
    logic                   w_rp_level_unused;
    logic                   w_st_level_unused;

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run_pause (
        .clk     (clk),
        .reset_n (reset_n),
        .button  (btn_run_pause),
        .level   (w_rp_level_unused),
        .press   (w_rp_press)
    );

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk     (clk),
        .reset_n (reset_n),
        .button  (btn_step),
        .level   (w_st_level_unused),
        .press   (w_st_press)
    );

    // Tick when the low div_sel bits of the free-running counter are all
    // ones; out-of-range selections saturate at the full counter width.
    always_comb begin
        w_sel  = (div_sel > SEL_W'(DIV_WIDTH)) ? SEL_W'(DIV_WIDTH) : div_sel;
        w_mask = '0;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            if (SEL_W'(i) < w_sel) begin
                w_mask[i] = 1'b1;
            end
        end
        w_tick = ((r_div_cnt & w_mask) == w_mask);
    end

    // The enable is the only unregistered output so the soc sees the tick
    // in the same cycle the divider produces it.
    always_comb begin
        soc_clk_en = 1'b0;
        case (r_state)
            ST_LOAD, ST_RUN, ST_STEP: soc_clk_en = w_tick;
            default:                  soc_clk_en = 1'b0;
        endcase
    end

    assign run_state = r_state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div_cnt           <= '0;
            r_state             <= ST_LOAD;
            r_burst             <= '0;
            load_run            <= 1'b0;
            hack_external_reset <= 1'b1;
            cycle_count         <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;

            // Ticks spent feeding the ROM loader are not CPU cycles.
            if (soc_clk_en && (r_state != ST_LOAD)) begin
                cycle_count <= cycle_count + 1'b1;
            end

            case (r_state)
                ST_LOAD: begin
                    load_run <= 1'b1;
                    if (load_done && w_tick) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    load_run            <= 1'b0;
                    hack_external_reset <= 1'b0;
                    r_state             <= (START_PAUSED != 0) ? ST_PAUSE : ST_RUN;
                end
                ST_RUN: begin
                    if (w_rp_press) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_rp_press) begin
                        r_state <= ST_RUN;
                    end else if (w_st_press) begin
                        r_state <= ST_STEP;
                        r_burst <= (step_count == '0) ? BURST_WIDTH'(1) : step_count;
                    end
                end
                ST_STEP: begin
                    if (w_rp_press) begin
                        r_state <= ST_RUN;
                    end else if (w_tick) begin
                        r_burst <= r_burst - 1'b1;
                        if (r_burst == BURST_WIDTH'(1)) begin
                            r_state <= ST_PAUSE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_run_controller
// Purpose  : Self-checking bench for soc_run_controller. A behavioural model
//            (cycle arithmetic for the divider, raw-sample history for the
//            debouncers, step/run rules for the state) is compared every
//            cycle, alongside a table of scenario vectors and hand-written
//            corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_run_controller;

    localparam int DW  = 5;
    localparam int DB  = 40;
    localparam int BW  = 8;
    localparam int CCW = 8;
    localparam int SP  = 0;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           btn_run_pause;
    logic           btn_step;
    logic [2:0]     div_sel;
    logic [BW-1:0]  step_count;
    logic           load_done;
    logic           load_run;
    logic           hack_external_reset;
    logic           soc_clk_en;
    logic [2:0]     run_state;
    logic [CCW-1:0] cycle_count;

    soc_run_controller #(
        .DIV_WIDTH         (DW),
        .DEBOUNCE_CYCLES   (DB),
        .BURST_WIDTH       (BW),
        .START_PAUSED      (SP),
        .CYCLE_COUNT_WIDTH (CCW)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .btn_run_pause       (btn_run_pause),
        .btn_step            (btn_step),
        .div_sel             (div_sel),
        .step_count          (step_count),
        .load_done           (load_done),
        .load_run            (load_run),
        .hack_external_reset (hack_external_reset),
        .soc_clk_en          (soc_clk_en),
        .run_state           (run_state),
        .cycle_count         (cycle_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // States: 0 LOAD, 1 RELEASE, 2 RUN, 3 PAUSE, 4 STEP
    int m_state, m_div, m_cc, m_lr, m_hr, m_burst;
    int m_lvl [2];
    int m_prs [2];
    int hist  [2][DB+2];   // hist[b][i] = raw button value i edges ago
    bit m_valid = 1'b0;
    int total_pulses = 0;
    bit en_seen;

    function automatic int m_tick();
        int s;
        s = (div_sel > DW) ? DW : int'(div_sel);
        return (((m_div + 1) % (1 << s)) == 0) ? 1 : 0;
    endfunction

    function automatic int m_en();
        return (m_state == 0 || m_state == 2 || m_state == 4) ? m_tick() : 0;
    endfunction

    task automatic model_edge();
        int raw [2];
        int tk;
        int en_v;
        int alld;
        if (!reset_n) begin
            m_state = 0; m_div = 0; m_cc = 0; m_lr = 0; m_hr = 1; m_burst = 0;
            for (int b = 0; b < 2; b++) begin
                m_lvl[b] = 0;
                m_prs[b] = 0;
                for (int i = 0; i < DB + 2; i++) hist[b][i] = 0;
            end
            m_valid = 1'b1;
        end else begin
            tk   = m_tick();
            en_v = m_en();
            if ((m_state == 2 || m_state == 4) && en_v != 0) m_cc = (m_cc + 1) % (1 << CCW);
            case (m_state)
                0: begin m_lr = 1; if (load_done && tk != 0) m_state = 1; end
                1: begin m_lr = 0; m_hr = 0; m_state = (SP != 0) ? 3 : 2; end
                2: if (m_prs[0] != 0) m_state = 3;
                3: begin
                    if (m_prs[0] != 0) m_state = 2;
                    else if (m_prs[1] != 0) begin
                        m_state = 4;
                        m_burst = (step_count == 0) ? 1 : int'(step_count);
                    end
                end
                4: begin
                    if (m_prs[0] != 0) m_state = 2;
                    else if (tk != 0) begin
                        m_burst--;
                        if (m_burst == 0) m_state = 3;
                    end
                end
                default: ;
            endcase
            m_div  = (m_div + 1) % (1 << DW);
            raw[0] = int'(btn_run_pause);
            raw[1] = int'(btn_step);
            for (int b = 0; b < 2; b++) begin
                for (int i = DB + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = raw[b];
                // Two edges of synchronizer delay, then DB consecutive samples
                // that all disagree with the level flip it.
                alld = 1;
                for (int i = 2; i <= DB + 1; i++) if (hist[b][i] == m_lvl[b]) alld = 0;
                m_prs[b] = 0;
                if (alld != 0) begin
                    m_lvl[b] = 1 - m_lvl[b];
                    m_prs[b] = m_lvl[b];
                end
            end
        end
    endtask

    // One clock cycle: check the enable with this cycle's inputs, predict the
    // edge, then check the registered outputs after it.
    task automatic cyc();
        #1;
        en_seen = soc_clk_en;
        if (m_valid) chk("soc_clk_en", int'(soc_clk_en), m_en());
        if (soc_clk_en === 1'b1) total_pulses++;
        model_edge();
        @(posedge clk);
        #1;
        chk("run_state", int'(run_state), m_state);
        chk("load_run", int'(load_run), m_lr);
        chk("hack_external_reset", int'(hack_external_reset), m_hr);
        chk("cycle_count", int'(cycle_count), m_cc);
    endtask

    typedef struct {
        int sel;
        int sc;
        int rp;
        int st;
        int len;
        int exp_state;
        int exp_pulses;
    } vec_t;

    vec_t tab [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int last;
        int found;
        int changes;
        int got;
        int p0;
        int hold_rp;
        int hold_st;
        logic [CCW-1:0] cc0;
        logic [CCW-1:0] d;

        //         sel sc   rp  st  len  state pulses
        tab[0]  = '{3, 3,   0,  45, 150, 3,   3};
        tab[1]  = '{3, 0,   0,  45, 150, 3,   1};
        tab[2]  = '{1, 5,   0,  45, 150, 3,   5};
        tab[3]  = '{7, 2,   0,  45, 150, 3,   2};
        tab[4]  = '{0, 1,   45, 0,  150, 2,   107};
        tab[5]  = '{2, 1,   45, 0,  150, 3,   -1};
        tab[6]  = '{0, 200, 0,  45, 150, 4,   107};
        tab[7]  = '{0, 200, 45, 0,  150, 2,   150};
        tab[8]  = '{0, 1,   45, 0,  150, 3,   43};
        tab[9]  = '{0, 1,   45, 45, 150, 2,   107};
        tab[10] = '{0, 1,   45, 0,  150, 3,   43};

        reset_n = 1'b0; btn_run_pause = 1'b0; btn_step = 1'b0;
        load_done = 1'b0; div_sel = 3'd2; step_count = 8'd1;

        // Reset state
        cyc(); cyc();
        chk("reset_state", int'(run_state), 0);
        chk("reset_hold", int'(hack_external_reset), 1);
        chk("reset_load_run", int'(load_run), 0);
        chk("reset_cycle_count", int'(cycle_count), 0);
        reset_n = 1'b1;
        cyc();
        chk("load_run_first_cycle", int'(load_run), 1);

        // Loading with a 4-cycle tick
        pulses = 0; last = -1;
        for (int i = 0; i < 200 && pulses < 10; i++) begin
            cyc();
            if (en_seen) begin
                if (last >= 0) chk("load_tick_gap", i - last, 4);
                last = i;
                pulses++;
            end
        end
        chk("load_ticks_seen", pulses, 10);
        load_done = 1'b1;
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            cyc();
            found = en_seen ? 1 : 0;
        end
        chk("load_done_tick", found, 1);
        chk("release_state", int'(run_state), 1);
        chk("release_hold_still_high", int'(hack_external_reset), 1);
        cyc();
        chk("run_after_release", int'(run_state), 2);
        chk("hold_released", int'(hack_external_reset), 0);
        chk("load_run_dropped", int'(load_run), 0);

        // RUN at full rate, then pause via a long press
        div_sel = 3'd0;
        cc0 = cycle_count; p0 = total_pulses;
        repeat (20) cyc();
        d = cycle_count - cc0;
        chk("run_cc_delta", int'(d), 20);
        chk("run_pulses", total_pulses - p0, 20);
        btn_run_pause = 1'b1;
        for (int j = 1; j <= 50; j++) begin
            cyc();
            if (j == 42) chk("pause_not_yet", int'(run_state), 2);
            if (j == 43) chk("pause_entered", int'(run_state), 3);
        end
        btn_run_pause = 1'b0;
        cc0 = cycle_count; p0 = total_pulses;
        repeat (50) cyc();
        d = cycle_count - cc0;
        chk("pause_cc_frozen", int'(d), 0);
        chk("pause_no_pulses", total_pulses - p0, 0);

        // Scenario table
        for (int e = 0; e < 11; e++) begin
            div_sel    = 3'(tab[e].sel);
            step_count = 8'(tab[e].sc);
            p0 = total_pulses;
            for (int c = 1; c <= tab[e].len; c++) begin
                btn_run_pause = (c <= tab[e].rp);
                btn_step      = (c <= tab[e].st);
                cyc();
            end
            btn_run_pause = 1'b0;
            btn_step      = 1'b0;
            chk($sformatf("vec%0d_state", e), int'(run_state), tab[e].exp_state);
            if (tab[e].exp_pulses >= 0)
                chk($sformatf("vec%0d_pulses", e), total_pulses - p0, tab[e].exp_pulses);
        end

        // Bouncy run/pause button while paused
        div_sel = 3'd0;
        changes = 0;
        for (int c = 0; c < 100; c++) begin
            btn_run_pause = (((c / 5) % 2) == 0);
            cyc();
            if (run_state != 3'd3) changes++;
        end
        chk("bounce_no_press", changes, 0);
        btn_run_pause = 1'b1;
        got = 0;
        for (int j = 1; j <= 60 && got == 0; j++) begin
            cyc();
            if (run_state == 3'd2) got = j;
        end
        chk("bounce_latency", got, 43);
        repeat (60) cyc();
        chk("bounce_single_press", int'(run_state), 2);
        btn_run_pause = 1'b0;
        repeat (45) cyc();

        // Reset while running
        reset_n = 1'b0;
        cyc();
        chk("midrst_state", int'(run_state), 0);
        chk("midrst_hold", int'(hack_external_reset), 1);
        chk("midrst_cc", int'(cycle_count), 0);
        chk("midrst_load_run", int'(load_run), 0);
        reset_n = 1'b1;
        cyc();
        chk("midrst_load_run_next", int'(load_run), 1);

        // Randomized operation against the model
        hold_rp = 0; hold_st = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_rp == 0) begin
                btn_run_pause = 1'($urandom_range(0, 1));
                hold_rp = $urandom_range(1, 90);
            end else hold_rp--;
            if (hold_st == 0) begin
                btn_step = 1'($urandom_range(0, 1));
                hold_st = $urandom_range(1, 90);
            end else hold_st--;
            if ($urandom_range(0, 39) == 0)
                div_sel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 39) == 0)
                step_count = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) load_done = ~load_done;
            reset_n = ($urandom_range(0, 999) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
